// File: rtl/gost_sbox_bank.sv
// Bank of NBOX independent 2^AW x DW substitution tables for the GOST 28147-89 S-layer.
// The tables are loaded row by row over a valid/ready stream and read as one registered parallel lookup per cycle.
module gost_sbox_bank #(
    parameter int NBOX = 8,
    parameter int AW   = 4,
    parameter int DW   = 4
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 LD_START,
    input  logic                 LD_VALID,
    output logic                 LD_READY,
    input  logic [NBOX*DW-1:0]   LD_DATA,
    output logic                 TBL_OK,
    input  logic                 SUB_VALID,
    input  logic [NBOX*DW-1:0]   SUB_IN,
    output logic                 SUB_VOUT,
    output logic [NBOX*DW-1:0]   SUB_OUT
);

    localparam int W     = NBOX * DW;
    localparam int DEPTH = 1 << AW;

    // Each lane nibble is used directly as the row address, so the widths must agree.
    if (AW != DW) begin : g_width_check
        $error("gost_sbox_bank: AW (%0d) must equal DW (%0d)", AW, DW);
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   ptr_q;
    logic [AW-1:0]   ptr_d;
    logic            tbl_ok_q;
    logic            sub_vout_q;
    logic [W-1:0]    sub_out_q;
    logic [W-1:0]    sub_out_d;
    logic            ld_ready_s;
    logic            beat_s;
    logic            sub_acc_s;

    // Table storage is deliberately not reset; TBL_OK qualifies its contents.
    logic [DW-1:0]   mem_q [NBOX][DEPTH];

    // Load handshake and lookup acceptance qualifiers.
    always_comb begin
        ld_ready_s = 1'b0;
        if ((state_q == ST_LOAD) && !LD_START) begin
            ld_ready_s = 1'b1;
        end else begin
            ld_ready_s = 1'b0;
        end
        beat_s    = ld_ready_s & LD_VALID;
        sub_acc_s = SUB_VALID & (state_q == ST_READY);
        ptr_d     = ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end

    // Parallel read: lane i addresses box i with its own nibble of SUB_IN.
    always_comb begin
        sub_out_d = '0;
        for (int i = 0; i < NBOX; i++) begin
            sub_out_d[i*DW +: DW] = mem_q[i][SUB_IN[i*DW +: DW]];
        end
    end

    // Row write: one accepted beat fills row ptr of every box.
    always_ff @(posedge CLK) begin
        if (beat_s) begin
            for (int i = 0; i < NBOX; i++) begin
                mem_q[i][ptr_q] <= LD_DATA[i*DW +: DW];
            end
        end
    end

    // Load sequencer, table-valid flag and registered lookup output.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_EMPTY;
            ptr_q      <= '0;
            tbl_ok_q   <= 1'b0;
            sub_vout_q <= 1'b0;
            sub_out_q  <= '0;
        end else begin
            // A lookup in the LD_START cycle still sees the old table.
            sub_vout_q <= sub_acc_s;
            if (sub_acc_s) begin
                sub_out_q <= sub_out_d;
            end
            if (LD_START) begin
                state_q  <= ST_LOAD;
                ptr_q    <= '0;
                tbl_ok_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        tbl_ok_q <= 1'b0;
                    end
                    ST_LOAD: begin
                        if (beat_s) begin
                            ptr_q <= ptr_d;
                            if (ptr_q == {AW{1'b1}}) begin
                                state_q  <= ST_READY;
                                tbl_ok_q <= 1'b1;
                            end
                        end
                    end
                    ST_READY: begin
                        tbl_ok_q <= 1'b1;
                    end
                    default: begin
                        state_q  <= ST_EMPTY;
                        ptr_q    <= '0;
                        tbl_ok_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign LD_READY = ld_ready_s;
    assign TBL_OK   = tbl_ok_q;
    assign SUB_VOUT = sub_vout_q;
    assign SUB_OUT  = sub_out_q;

endmodule

// File: tb/tb_gost_sbox_bank.sv
// Directed bench for gost_sbox_bank: expected lookups go into a queue, a monitor pops them on each SUB_VOUT.
module tb_gost_sbox_bank;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RSTN = 1'b0;
    logic         LD_START = 1'b0;
    logic         LD_VALID = 1'b0;
    logic [W-1:0] LD_DATA = '0;
    logic         SUB_VALID = 1'b0;
    logic [W-1:0] SUB_IN = '0;
    logic         LD_READY;
    logic         TBL_OK;
    logic         SUB_VOUT;
    logic [W-1:0] SUB_OUT;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  exp_q[$];
    logic [31:0]  mon_exp;

    gost_sbox_bank #(.NBOX(8), .AW(4), .DW(4)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_DATA(LD_DATA),
        .TBL_OK(TBL_OK),
        .SUB_VALID(SUB_VALID), .SUB_IN(SUB_IN), .SUB_VOUT(SUB_VOUT), .SUB_OUT(SUB_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every SUB_VOUT pulse must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (SUB_VOUT === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vout: got SUB_OUT %h with SUB_VOUT=1 expected no output", SUB_OUT);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sub_out", SUB_OUT, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] row_a(input int k);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = 4'((k + i) % 16);
        return r;
    endfunction

    function automatic logic [31:0] row_b(input int k);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = 4'(15 - k);
        return r;
    endfunction

    task automatic start();
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
    endtask

    task automatic load(input bit tab_b, input int nbeats, input bit gaps);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps) begin
                LD_VALID = 1'b0;
                tick();
            end
            LD_VALID = 1'b1;
            LD_DATA  = tab_b ? row_b(k) : row_a(k);
            if (k == 15) begin
                @(negedge CLK);
                chk("tbl_ok_before_last", TBL_OK, 32'd0);
            end
            tick();
        end
        LD_VALID = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] a, input logic [31:0] e, input bit acc);
        SUB_VALID = 1'b1;
        SUB_IN    = a;
        if (acc) exp_q.push_back(e);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        SUB_VALID = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ld_ready", LD_READY, 32'd0);
        chk("rst_tbl_ok", TBL_OK, 32'd0);
        chk("rst_sub_vout", SUB_VOUT, 32'd0);
        chk("rst_sub_out", SUB_OUT, 32'h0);
        @(negedge CLK);
        RSTN = 1'b1;
        repeat (3) tick();
        chk("empty_no_vout", SUB_VOUT, 32'd0);
        chk("empty_ld_ready", LD_READY, 32'd0);
        SUB_VALID = 1'b0;

        // Back-to-back load of table A
        LD_START = 1'b1;
        LD_VALID = 1'b1;
        LD_DATA  = row_a(0);
        #1;
        chk("ld_ready_start_cycle", LD_READY, 32'd0);
        tick();
        LD_START = 1'b0;
        #1;
        chk("ld_ready_in_load", LD_READY, 32'd1);
        load(1'b0, 16, 1'b0);
        chk("tbl_ok_after_last", TBL_OK, 32'd1);
        chk("ld_ready_in_ready", LD_READY, 32'd0);
        lookup(32'h00000000, 32'h76543210, 1'b1);
        lookup(32'hFFFFFFFF, 32'h6543210F, 1'b1);
        lookup(32'h01234567, 32'h77777777, 1'b1);
        SUB_VALID = 1'b0;
        repeat (2) tick();
        chk("hold_vout", SUB_VOUT, 32'd0);
        chk("hold_sub_out", SUB_OUT, 32'h77777777);

        // Same table with a gap before every beat
        start();
        load(1'b0, 16, 1'b1);
        chk("gap_tbl_ok_after_last", TBL_OK, 32'd1);
        lookup(32'h00000000, 32'h76543210, 1'b1);
        lookup(32'hFFFFFFFF, 32'h6543210F, 1'b1);
        SUB_VALID = 1'b0;
        tick();

        // Restart after 7 beats, then table B
        start();
        load(1'b0, 7, 1'b0);
        chk("partial_tbl_ok", TBL_OK, 32'd0);
        LD_START = 1'b1;
        LD_VALID = 1'b1;
        LD_DATA  = row_b(0);
        #1;
        chk("ld_ready_restart", LD_READY, 32'd0);
        tick();
        LD_START = 1'b0;
        load(1'b1, 16, 1'b0);
        chk("b_tbl_ok_after_last", TBL_OK, 32'd1);
        lookup(32'h00000000, 32'hFFFFFFFF, 1'b1);
        lookup(32'h01234567, 32'hFEDCBA98, 1'b1);
        SUB_VALID = 1'b0;
        tick();

        // LD_START in READY together with a lookup: old table answers, next lookup dropped
        LD_START  = 1'b1;
        SUB_VALID = 1'b1;
        SUB_IN    = 32'h00000000;
        exp_q.push_back(32'hFFFFFFFF);
        tick();
        LD_START = 1'b0;
        lookup(32'hFFFFFFFF, 32'h0, 1'b0);
        SUB_VALID = 1'b0;
        chk("reload_tbl_ok_low", TBL_OK, 32'd0);
        load(1'b0, 16, 1'b0);
        chk("reload_tbl_ok", TBL_OK, 32'd1);
        lookup(32'h00000000, 32'h76543210, 1'b1);

        // Async reset between a request and its output
        SUB_IN = 32'hFFFFFFFF;
        @(negedge CLK);
        #1;
        RSTN = 1'b0;
        #1;
        chk("arst_sub_vout", SUB_VOUT, 32'd0);
        chk("arst_sub_out", SUB_OUT, 32'h0);
        chk("arst_tbl_ok", TBL_OK, 32'd0);
        SUB_VALID = 1'b0;
        tick();
        @(negedge CLK);
        RSTN = 1'b1;
        tick();
        chk("post_rst_tbl_ok", TBL_OK, 32'd0);
        chk("post_rst_ld_ready", LD_READY, 32'd0);

        repeat (3) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
